// File: rtl/ysyx_23060077_trap_ctrl.sv
// ysyx_23060077_trap_ctrl
// Trap entry / mret sequencer sitting between the EXU and the CSR file.
// It turns ecall, ebreak, illegal-instruction and mret requests into a short
// series of ordinary CSR write-port transactions, and then issues a one-cycle
// redirect to the IFU. The CSR write port is shared with the EXU's
// CSR-instruction writes: the EXU owns it in IDLE, and the sequencer owns it
// everywhere else.
// Optional machine-timer interrupt entry is compiled in when the macro
// YSYX_23060077_TRAP_IRQ_EN is defined. That build adds the irq_timer and
// irq_pc ports.
module ysyx_23060077_trap_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_type,
  input  logic [DATA_WIDTH-1:0]     req_pc,
  input  logic [DATA_WIDTH-1:0]     req_tval,
  input  logic                      inst_wr_valid,
  output logic                      inst_wr_ready,
  input  logic [CSR_ADDR_WIDTH-1:0] inst_wr_addr,
  input  logic [DATA_WIDTH-1:0]     inst_wr_data,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec,
  input  logic [DATA_WIDTH-1:0]     csr_mepc,
`ifdef YSYX_23060077_TRAP_IRQ_EN
  input  logic                      irq_timer,
  input  logic [DATA_WIDTH-1:0]     irq_pc,
`endif
  output logic                      csr_wr_en,
  output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr,
  output logic [DATA_WIDTH-1:0]     csr_wr_data,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc,
  output logic                      busy
);

  localparam logic [1:0] TYPE_ECALL   = 2'b00;
  localparam logic [1:0] TYPE_MRET    = 2'b01;
  localparam logic [1:0] TYPE_ILLEGAL = 2'b10;
  localparam logic [1:0] TYPE_EBREAK  = 2'b11;

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDR_WIDTH'(12'h343);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_TVAL   = 3'd3,
    S_W_STATUS = 3'd4,
    S_REDIR    = 3'd5
  } state_t;

  // Clear the two low bits. This is used for both mepc and the mtvec base.
  function automatic logic [DATA_WIDTH-1:0] align4(input logic [DATA_WIDTH-1:0] v);
    align4 = {v[DATA_WIDTH-1:2], 2'b00};
  endfunction

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [DATA_WIDTH-1:0] entry_status(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP stays M (only M-mode exists).
  function automatic logic [DATA_WIDTH-1:0] return_status(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mcause encoding. An interrupt sets the top bit, with code 7 (machine timer).
  function automatic logic [DATA_WIDTH-1:0] cause_code(input logic [1:0] t, input logic irq);
    logic [DATA_WIDTH-1:0] c;
    c = '0;
    if (irq) begin
      c[DATA_WIDTH-1] = 1'b1;
      c[3:0]          = 4'd7;
    end else begin
      case (t)
        TYPE_ILLEGAL: c[3:0] = 4'd2;
        TYPE_EBREAK:  c[3:0] = 4'd3;
        TYPE_ECALL:   c[3:0] = 4'd11;
        default:      c[3:0] = 4'd11;
      endcase
    end
    return c;
  endfunction

  state_t                state;
  logic [1:0]            type_q;
  logic                  irq_q;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] tval_q;
  logic [DATA_WIDTH-1:0] mstatus_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic [DATA_WIDTH-1:0] mepc_q;

  logic                  irq_take;
  logic [DATA_WIDTH-1:0] entry_pc;
  logic                  accept;
  logic                  is_mret_q;
  logic [DATA_WIDTH-1:0] trap_target;

`ifdef YSYX_23060077_TRAP_IRQ_EN
  // An enabled timer interrupt wins over a simultaneous EXU request. It takes
  // its epc from the request when one is present.
  assign irq_take = (state == S_IDLE) & irq_timer & csr_mstatus[3];
  assign entry_pc = (irq_take & ~req_valid) ? irq_pc : req_pc;
`else
  assign irq_take = 1'b0;
  assign entry_pc = req_pc;
`endif

  assign req_ready     = (state == S_IDLE) & ~irq_take;
  assign inst_wr_ready = (state == S_IDLE);
  assign accept        = irq_take | (req_valid & req_ready);
  assign is_mret_q     = (type_q == TYPE_MRET) & ~irq_q;

  // Exception target is the mtvec base. Only interrupts honour vectored mode.
  always_comb begin
    trap_target = align4(mtvec_q);
    if (irq_q && (mtvec_q[1:0] == 2'b01)) begin
      trap_target = align4(mtvec_q) + DATA_WIDTH'(32'd28);
    end else begin
      trap_target = align4(mtvec_q);
    end
  end

  // Sequencing FSM, request snapshots, and the registered redirect/busy outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      type_q         <= 2'b00;
      irq_q          <= 1'b0;
      epc_q          <= '0;
      tval_q         <= '0;
      mstatus_q      <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          redirect_valid <= 1'b0;
          if (accept) begin
            type_q    <= req_type;
            irq_q     <= irq_take;
            epc_q     <= align4(entry_pc);
            tval_q    <= irq_take ? '0 : req_tval;
            mstatus_q <= csr_mstatus;
            mtvec_q   <= csr_mtvec;
            mepc_q    <= csr_mepc;
            busy      <= 1'b1;
            if (!irq_take && (req_type == TYPE_MRET)) begin
              state <= S_W_STATUS;
            end else begin
              state <= S_W_EPC;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_W_EPC:   state <= S_W_CAUSE;
        S_W_CAUSE: state <= S_W_TVAL;
        S_W_TVAL:  state <= S_W_STATUS;
        S_W_STATUS: begin
          state          <= S_REDIR;
          redirect_valid <= 1'b1;
          redirect_pc    <= is_mret_q ? mepc_q : trap_target;
        end
        S_REDIR: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  // Write-port arbitration. In IDLE the port passes EXU writes through;
  // otherwise the sequencer drives it from the snapshots. Reset holds the port off.
  always_comb begin
    csr_wr_en   = 1'b0;
    csr_wr_addr = '0;
    csr_wr_data = '0;
    if (reset) begin
      csr_wr_en   = 1'b0;
      csr_wr_addr = '0;
      csr_wr_data = '0;
    end else begin
      case (state)
        S_IDLE: begin
          csr_wr_en   = inst_wr_valid;
          csr_wr_addr = inst_wr_addr;
          csr_wr_data = inst_wr_data;
        end
        S_W_EPC: begin
          csr_wr_en   = 1'b1;
          csr_wr_addr = ADDR_MEPC;
          csr_wr_data = epc_q;
        end
        S_W_CAUSE: begin
          csr_wr_en   = 1'b1;
          csr_wr_addr = ADDR_MCAUSE;
          csr_wr_data = cause_code(type_q, irq_q);
        end
        S_W_TVAL: begin
          csr_wr_en   = 1'b1;
          csr_wr_addr = ADDR_MTVAL;
          csr_wr_data = (!irq_q && (type_q == TYPE_ILLEGAL)) ? tval_q : '0;
        end
        S_W_STATUS: begin
          csr_wr_en   = 1'b1;
          csr_wr_addr = ADDR_MSTATUS;
          csr_wr_data = is_mret_q ? return_status(mstatus_q) : entry_status(mstatus_q);
        end
        default: begin
          csr_wr_en   = 1'b0;
          csr_wr_addr = '0;
          csr_wr_data = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_trap_ctrl.sv
// Randomized self-checking bench for ysyx_23060077_trap_ctrl.
// Expected CSR write sequences and redirect targets come from a small
// transaction-level model that applies the trap/mret rules with plain
// arithmetic on whole words.
module tb_ysyx_23060077_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_pc;
  logic [31:0] req_tval;
  logic        inst_wr_valid;
  logic        inst_wr_ready;
  logic [11:0] inst_wr_addr;
  logic [31:0] inst_wr_data;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
`ifdef YSYX_23060077_TRAP_IRQ_EN
  logic        irq_timer;
  logic [31:0] irq_pc;
`endif

  ysyx_23060077_trap_ctrl #(.DATA_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_pc         (req_pc),
    .req_tval       (req_tval),
    .inst_wr_valid  (inst_wr_valid),
    .inst_wr_ready  (inst_wr_ready),
    .inst_wr_addr   (inst_wr_addr),
    .inst_wr_data   (inst_wr_data),
    .csr_mstatus    (csr_mstatus),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
`ifdef YSYX_23060077_TRAP_IRQ_EN
    .irq_timer      (irq_timer),
    .irq_pc         (irq_pc),
`endif
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_data    (csr_wr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Expected transaction produced by the model.
  logic [11:0] exp_addr [4];
  logic [31:0] exp_data [4];
  int          exp_n;
  logic [31:0] exp_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: list of (addr, data) writes plus the redirect target.
  task automatic model_req(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] tval,
                           input logic [31:0] ms, input logic [31:0] tvec, input logic [31:0] mepc,
                           input bit irq);
    logic [31:0] cause;
    if (!irq && t == 2'b01) begin
      exp_n       = 1;
      exp_addr[0] = 12'h300;
      exp_data[0] = (ms & ~32'h1888) | 32'h1880 | ((ms & 32'h80) >> 4);
      exp_pc      = mepc;
    end else begin
      if (irq)              cause = 32'h8000_0007;
      else if (t == 2'b00)  cause = 32'd11;
      else if (t == 2'b10)  cause = 32'd2;
      else                  cause = 32'd3;
      exp_n       = 4;
      exp_addr[0] = 12'h341; exp_data[0] = pc - (pc % 32'd4);
      exp_addr[1] = 12'h342; exp_data[1] = cause;
      exp_addr[2] = 12'h343; exp_data[2] = (!irq && t == 2'b10) ? tval : 32'd0;
      exp_addr[3] = 12'h300; exp_data[3] = (ms & ~32'h1888) | 32'h1800 | ((ms & 32'h8) << 4);
      exp_pc      = tvec - (tvec % 32'd4);
      if (irq && (tvec % 32'd4) == 32'd1) exp_pc = exp_pc + 32'd28;
    end
  endtask

  // Random noise on all inputs while the controller is busy: it must rely only on snapshots.
  task automatic scramble();
    req_valid     = 1'($urandom_range(0, 1));
    req_type      = 2'($urandom_range(0, 3));
    req_pc        = $urandom;
    req_tval      = $urandom;
    csr_mstatus   = $urandom;
    csr_mtvec     = $urandom;
    csr_mepc      = $urandom;
    inst_wr_valid = 1'($urandom_range(0, 1));
    inst_wr_addr  = 12'($urandom);
    inst_wr_data  = $urandom;
  endtask

  // One full request from IDLE back to IDLE, checked cycle by cycle.
  task automatic do_req(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] tval,
                        input logic [31:0] ms, input logic [31:0] tvec, input logic [31:0] mepc,
                        input bit exu_wr, input logic [11:0] wa, input logic [31:0] wd,
                        input bit irq, input bit rv, input logic [31:0] ipc);
    logic [31:0] epc_src;
    req_valid = rv; req_type = t; req_pc = pc; req_tval = tval;
    csr_mstatus = ms; csr_mtvec = tvec; csr_mepc = mepc;
    inst_wr_valid = exu_wr; inst_wr_addr = wa; inst_wr_data = wd;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer = irq; irq_pc = ipc;
`endif
    epc_src = (irq && !rv) ? ipc : pc;
    model_req(t, epc_src, tval, ms, tvec, mepc, irq);
    @(negedge clock);
    check_eq("c0_req_ready", req_ready, !irq);
    check_eq("c0_busy", busy, 1'b0);
    check_eq("c0_inst_wr_ready", inst_wr_ready, 1'b1);
    check_eq("c0_pass_en", csr_wr_en, exu_wr);
    if (exu_wr) begin
      check_eq("c0_pass_addr", csr_wr_addr, wa);
      check_eq("c0_pass_data", csr_wr_data, wd);
    end
    @(posedge clock); #1;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer = 1'b0;
`endif
    scramble();
    for (int k = 0; k < exp_n; k++) begin
      @(negedge clock);
      check_eq("wr_en", csr_wr_en, 1'b1);
      check_eq("wr_addr", csr_wr_addr, exp_addr[k]);
      check_eq("wr_data", csr_wr_data, exp_data[k]);
      check_eq("wr_busy", busy, 1'b1);
      check_eq("wr_inst_ready", inst_wr_ready, 1'b0);
      check_eq("wr_req_ready", req_ready, 1'b0);
      check_eq("wr_no_redirect", redirect_valid, 1'b0);
      @(posedge clock); #1;
      scramble();
    end
    @(negedge clock);
    check_eq("redir_valid", redirect_valid, 1'b1);
    check_eq("redir_pc", redirect_pc, exp_pc);
    check_eq("redir_wr_en", csr_wr_en, 1'b0);
    check_eq("redir_busy", busy, 1'b1);
    check_eq("redir_inst_ready", inst_wr_ready, 1'b0);
    @(posedge clock); #1;
    scramble();
    @(negedge clock);
    check_eq("end_redirect", redirect_valid, 1'b0);
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_req_ready", req_ready, 1'b1);
    check_eq("end_inst_ready", inst_wr_ready, 1'b1);
    check_eq("end_pass_en", csr_wr_en, inst_wr_valid);
    req_valid = 1'b0;
    inst_wr_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_type = 2'b00; req_pc = 32'd0; req_tval = 32'd0;
    inst_wr_valid = 1'b1; inst_wr_addr = 12'h305; inst_wr_data = 32'h1234;
    csr_mstatus = 32'd0; csr_mtvec = 32'd0; csr_mepc = 32'd0;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer = 1'b0; irq_pc = 32'd0;
`endif
    #2;
    check_eq("rst_wr_en", csr_wr_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_redirect", redirect_valid, 1'b0);
    check_eq("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    inst_wr_valid = 1'b0;
    @(posedge clock); #1;

    // Directed cases.
    do_req(2'b00, 32'h8000_0010, 32'h0, 32'h8, 32'h8000_0100, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    do_req(2'b01, 32'h8000_0100, 32'h0, 32'h1880, 32'h8000_0100, 32'h8000_0014, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    do_req(2'b10, 32'h8000_0020, 32'hFFFF_FFFF, 32'h0, 32'h8000_0200, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    do_req(2'b11, 32'h8000_0032, 32'h1234, 32'hFFFF_FFFF, 32'h8000_0303, 32'h0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    do_req(2'b00, 32'h8000_0040, 32'h0, 32'h8, 32'h8000_0100, 32'h0, 1'b1, 12'h305, 32'h200, 1'b0, 1'b1, 32'h0);

    // Reset during W_CAUSE.
    req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h8000_0050;
    csr_mstatus = 32'h8; csr_mtvec = 32'h8000_0400;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check_eq("mid_cause_addr", csr_wr_addr, 12'h342);
    inst_wr_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_wr_en", csr_wr_en, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_redirect", redirect_valid, 1'b0);
    check_eq("mid_rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    inst_wr_valid = 1'b0;
    #1;
    check_eq("post_rst_req_ready", req_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_eq("post_rst_no_redirect", redirect_valid, 1'b0);
      check_eq("post_rst_busy", busy, 1'b0);
    end
    @(posedge clock); #1;

    // Randomized requests, some alongside an EXU write in the accept cycle.
    for (int i = 0; i < 60; i++) begin
      do_req(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, $urandom,
             1'($urandom_range(0, 1)), 12'($urandom), $urandom, 1'b0, 1'b1, 32'h0);
    end

`ifdef YSYX_23060077_TRAP_IRQ_EN
    do_req(2'b00, 32'h8000_0060, 32'h0, 32'h8, 32'h8000_0101, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    do_req(2'b01, 32'h0, 32'h0, 32'h88, 32'h8000_0200, 32'h0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 32'h8000_0074);
    irq_timer = 1'b1; csr_mstatus = 32'h0; req_valid = 1'b0; inst_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("irq_masked_busy", busy, 1'b0);
      check_eq("irq_masked_wr_en", csr_wr_en, 1'b0);
      check_eq("irq_masked_ready", req_ready, 1'b1);
    end
    irq_timer = 1'b0;
    @(posedge clock); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
